// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and byte-mask helper for the load/store unit.
package lsu_pkg;

    localparam logic [1:0] SIZE_B    = 2'd0;
    localparam logic [1:0] SIZE_H    = 2'd1;
    localparam logic [1:0] SIZE_W    = 2'd2;
    localparam logic [1:0] SIZE_D    = 2'd3;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_AR,
        ST_RD_R,
        ST_WR_REQ,
        ST_WR_B,
        ST_RESP
    } lsu_state_e;

    // Byte-enable pattern for an access of the given size, before lane steering.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_B:  size_mask = 8'h01;
            SIZE_H:  size_mask = 8'h03;
            SIZE_W:  size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store shift/strobe generation and load extract/extend.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter  int DATA_W = 64,
    localparam int NBYTE  = DATA_W / 8,
    localparam int OFS_W  = $clog2(NBYTE)
) (
    input  logic [OFS_W-1:0]  offset_i,
    input  logic [1:0]        size_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] st_data_i,
    input  logic [DATA_W-1:0] ld_raw_i,
    output logic [DATA_W-1:0] st_data_o,
    output logic [NBYTE-1:0]  st_strb_o,
    output logic [DATA_W-1:0] ld_data_o
);

    logic [NBYTE-1:0]  bmask;
    logic [DATA_W-1:0] dmask;
    logic [DATA_W-1:0] shifted;
    logic              sbit;

    assign bmask     = NBYTE'(size_mask(size_i));
    assign st_data_o = st_data_i << {offset_i, 3'b000};
    assign st_strb_o = bmask << offset_i;
    assign shifted   = ld_raw_i >> {offset_i, 3'b000};

    always_comb begin
        dmask = '0;
        for (int i = 0; i < NBYTE; i++) dmask[i*8 +: 8] = {8{bmask[i]}};
        case (size_i)
            SIZE_B:  sbit = shifted[7];
            SIZE_H:  sbit = shifted[15];
            SIZE_W:  sbit = shifted[31];
            default: sbit = shifted[DATA_W-1];
        endcase
        // Bits above the access width are filled with the sign bit or cleared.
        ld_data_o = (shifted & dmask) | ((signed_i && sbit) ? ~dmask : '0);
    end

endmodule

// File: rtl/lsu_axi_ctrl.sv
// Handshaked load/store unit driving an AXI4-Lite-style read or write transaction.
module lsu_axi_ctrl
    import lsu_pkg::*;
#(
    parameter  int ADDR_W    = 64,
    parameter  int DATA_W    = 64,
    parameter  bit CHK_ALIGN = 1'b1,
    localparam int NBYTE     = DATA_W / 8,
    localparam int OFS_W     = $clog2(NBYTE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_ren,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arsize,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awsize,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [NBYTE-1:0]  wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    lsu_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic [NBYTE-1:0]  wstrb_q;
    logic              req_ready_q, arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic              resp_valid_q, err_q;

    logic [OFS_W-1:0]  ofs_d;
    logic [1:0]        size_d;
    logic [DATA_W-1:0] st_data_d, ld_data_d;
    logic [NBYTE-1:0]  st_strb_d;
    logic              misalign_d, illegal_d;

    // Store steering works on the live request; load extraction on the latched one.
    assign ofs_d  = (state_q == ST_IDLE) ? req_addr[OFS_W-1:0] : addr_q[OFS_W-1:0];
    assign size_d = (state_q == ST_IDLE) ? req_size : size_q;

    assign misalign_d = CHK_ALIGN &&
        ((req_addr[2:0] & 3'((4'd1 << req_size) - 4'd1)) != 3'd0);
    assign illegal_d  = (DATA_W == 32) && (req_size == SIZE_D);

    lsu_lane_align #(.DATA_W(DATA_W)) u_align (
        .offset_i  (ofs_d),
        .size_i    (size_d),
        .signed_i  (signed_q),
        .st_data_i (req_wdata),
        .ld_raw_i  (rdata),
        .st_data_o (st_data_d),
        .st_strb_o (st_strb_d),
        .ld_data_o (ld_data_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (req_valid) begin
                    addr_q      <= req_addr;
                    size_q      <= req_size;
                    signed_q    <= req_signed;
                    wdata_q     <= st_data_d;
                    wstrb_q     <= st_strb_d;
                    rdata_q     <= '0;
                    err_q       <= 1'b0;
                    req_ready_q <= 1'b0;
                    if (misalign_d || illegal_d) begin
                        err_q        <= 1'b1;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESP;
                    end else if (req_wen) begin
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state_q   <= ST_WR_REQ;
                    end else if (req_ren) begin
                        arvalid_q <= 1'b1;
                        state_q   <= ST_RD_AR;
                    end else begin
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESP;
                    end
                end
                ST_RD_AR: if (arready) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    state_q   <= ST_RD_R;
                end
                ST_RD_R: if (rvalid) begin
                    rready_q     <= 1'b0;
                    resp_valid_q <= 1'b1;
                    err_q        <= (rresp != RESP_OKAY);
                    rdata_q      <= (rresp == RESP_OKAY) ? ld_data_d : '0;
                    state_q      <= ST_RESP;
                end
                ST_WR_REQ: begin
                    if (awready) awvalid_q <= 1'b0;
                    if (wready)  wvalid_q  <= 1'b0;
                    // Each channel is done once its valid has dropped or handshakes now.
                    if ((!awvalid_q || awready) && (!wvalid_q || wready)) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WR_B;
                    end
                end
                ST_WR_B: if (bvalid) begin
                    bready_q     <= 1'b0;
                    resp_valid_q <= 1'b1;
                    err_q        <= (bresp != RESP_OKAY);
                    state_q      <= ST_RESP;
                end
                ST_RESP: if (resp_ready) begin
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign araddr     = addr_q;
    assign arsize     = {1'b0, size_q};
    assign arvalid    = arvalid_q;
    assign rready     = rready_q;
    assign awaddr     = addr_q;
    assign awsize     = {1'b0, size_q};
    assign awvalid    = awvalid_q;
    assign wdata      = wdata_q;
    assign wstrb      = wstrb_q;
    assign wvalid     = wvalid_q;
    assign bready     = bready_q;

endmodule

// File: tb/tb_lsu_axi_ctrl.sv
// Bench for lsu_axi_ctrl: directed scenarios plus randomized loads/stores against a reference model.
module tb_lsu_axi_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ren = 1'b0, req_wen = 1'b0, req_signed = 1'b0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_ready, resp_valid, resp_err;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic [63:0] araddr, awaddr, wdata;
    logic [2:0]  arsize, awsize;
    logic [7:0]  wstrb;
    logic        arvalid, rready, awvalid, wvalid, bready;
    logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [63:0] rdata = '0;
    logic [1:0]  rresp = '0, bresp = '0;

    int n_vec = 0, n_err = 0;

    lsu_axi_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_ren(req_ren), .req_wen(req_wen),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    // Observations gathered by the slave/driver for the last transaction.
    logic [63:0] o_rdata, o_araddr, o_awaddr, o_wdata;
    logic [2:0]  o_arsize, o_awsize;
    logic [7:0]  o_wstrb;
    logic        o_err;
    int          o_lat, o_aw_cyc, o_w_cyc;
    bit          o_bus_any, o_ar_hs, o_aw_hs, o_bready_early, o_unstable, o_rr_bad, o_timeout, o_req_ready_after;

    // Reference model: plain arithmetic on the access size and byte offset.
    function automatic logic [63:0] ref_load(input logic [63:0] raw, input logic [63:0] addr,
                                             input logic [1:0] sz, input logic sgn);
        int          nb  = 1 << sz;
        int          off = int'(addr % 8);
        logic [63:0] v   = raw >> (8 * off);
        logic [63:0] lim;
        if (nb == 8) return v;
        lim = 64'd1 << (8 * nb);
        v = v % lim;
        if (sgn && v >= lim / 2) v = v - lim;
        return v;
    endfunction

    function automatic logic [7:0] ref_strb(input logic [63:0] addr, input logic [1:0] sz);
        logic [7:0] s = '0;
        for (int i = 0; i < (1 << sz); i++) s[int'(addr % 8) + i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] ref_wlanes(input logic [63:0] wd, input logic [63:0] addr, input logic [1:0] sz);
        logic [63:0] w = '0;
        int off = int'(addr % 8);
        for (int i = 0; i < (1 << sz); i++) w[8*(off+i) +: 8] = wd[8*i +: 8];
        return w;
    endfunction

    function automatic logic [63:0] lane_mask(input logic [7:0] s);
        logic [63:0] m = '0;
        for (int j = 0; j < 8; j++) m[8*j +: 8] = {8{s[j]}};
        return m;
    endfunction

    // Drives one request and plays a slave with programmable per-channel wait states.
    task automatic run_txn(input logic ren, input logic wen, input logic [63:0] addr, input logic [1:0] sz,
                           input logic sgn, input logic [63:0] wd, input logic [63:0] bdata,
                           input logic [1:0] rr, input logic [1:0] br,
                           input int d_ar, input int d_r, input int d_aw, input int d_w,
                           input int d_b, input int d_resp);
        int c_ar = 0, c_r = 0, c_aw = 0, c_w = 0, c_b = 0, c_resp = 0, cyc = 0;
        bit resp_seen = 0, done = 0;
        o_rdata = 'x; o_err = 1'bx; o_araddr = 'x; o_awaddr = 'x; o_wdata = 'x; o_wstrb = 'x;
        o_arsize = 'x; o_awsize = 'x; o_lat = -1; o_aw_cyc = 0; o_w_cyc = 0;
        o_bus_any = 0; o_ar_hs = 0; o_aw_hs = 0; o_bready_early = 0; o_unstable = 0; o_rr_bad = 0;
        o_timeout = 0; o_req_ready_after = 0;
        @(negedge clk);
        for (int k = 0; k < 50 && !req_ready; k++) @(negedge clk);
        if (!req_ready) begin o_timeout = 1; return; end
        req_valid = 1'b1; req_ren = ren; req_wen = wen; req_addr = addr; req_size = sz;
        req_signed = sgn; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (!done && cyc < 300) begin
            arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0; resp_ready = 0;
            if (arvalid) begin
                o_bus_any = 1;
                if (c_ar == d_ar) begin arready = 1; o_ar_hs = 1; o_araddr = araddr; o_arsize = arsize; end
                else c_ar++;
            end
            if (rready) begin
                if (c_r == d_r) begin rvalid = 1; rdata = bdata; rresp = rr; end
                else c_r++;
            end
            if (awvalid) begin
                o_bus_any = 1; o_aw_cyc++;
                if (c_aw == d_aw) begin awready = 1; o_aw_hs = 1; o_awaddr = awaddr; o_awsize = awsize; end
                else c_aw++;
            end
            if (wvalid) begin
                o_w_cyc++;
                if (c_w == d_w) begin wready = 1; o_wdata = wdata; o_wstrb = wstrb; end
                else c_w++;
            end
            if (bready) begin
                if (awvalid || wvalid) o_bready_early = 1;
                if (c_b == d_b) begin bvalid = 1; bresp = br; end
                else c_b++;
            end
            if (resp_valid) begin
                if (!resp_seen) begin resp_seen = 1; o_lat = cyc; o_rdata = resp_rdata; o_err = resp_err; end
                else if (resp_rdata !== o_rdata || resp_err !== o_err) o_unstable = 1;
                if (req_ready !== 1'b0) o_rr_bad = 1;
                if (c_resp == d_resp) resp_ready = 1; else c_resp++;
            end else if (resp_seen) begin
                done = 1; o_req_ready_after = req_ready;
            end
            if (!done) begin @(negedge clk); cyc++; end
        end
        if (!done) o_timeout = 1;
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0; resp_ready = 0; rresp = 0; bresp = 0;
    endtask

    task automatic test_reset;
        n_vec++;
        if ({arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err} !== 7'b0) begin
            n_err++; $display("FAIL reset_valids got=%b exp=0", {arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err});
        end
        n_vec++;
        if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        n_vec++;
        if ({araddr, awaddr, wdata, wstrb, resp_rdata} !== '0) begin
            n_err++; $display("FAIL reset_data got araddr=%h wdata=%h wstrb=%h rdata=%h exp=0", araddr, wdata, wstrb, resp_rdata);
        end
    endtask

    task automatic test_signed_load;
        run_txn(1, 0, 64'h8000_0006, SIZE_H, 1, '0, 64'h8001_0000_0000_0000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if (o_timeout) begin n_err++; $display("FAIL sload_timeout got=1 exp=0"); end
        n_vec++;
        if (o_rdata !== 64'hFFFF_FFFF_FFFF_8001) begin n_err++; $display("FAIL sload_rdata got=%h exp=ffffffffffff8001", o_rdata); end
        n_vec++;
        if (o_err !== 1'b0) begin n_err++; $display("FAIL sload_err got=%b exp=0", o_err); end
        n_vec++;
        if (o_lat !== 3) begin n_err++; $display("FAIL sload_latency got=%0d exp=3", o_lat); end
        n_vec++;
        if (o_araddr !== 64'h8000_0006 || o_arsize !== 3'd1) begin
            n_err++; $display("FAIL sload_ar got=%h/%0d exp=80000006/1", o_araddr, o_arsize);
        end
        run_txn(1, 0, 64'h8000_0006, SIZE_H, 0, '0, 64'h8001_0000_0000_0000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if (o_rdata !== 64'h0000_0000_0000_8001) begin n_err++; $display("FAIL uload_rdata got=%h exp=8001", o_rdata); end
    endtask

    task automatic test_byte_store;
        run_txn(0, 1, 64'h8000_0003, SIZE_B, 0, 64'hAB, '0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if (o_wstrb !== 8'h08) begin n_err++; $display("FAIL bstore_wstrb got=%h exp=08", o_wstrb); end
        n_vec++;
        if (o_wdata[31:24] !== 8'hAB) begin n_err++; $display("FAIL bstore_wdata got=%h exp=ab", o_wdata[31:24]); end
        n_vec++;
        if (o_awaddr !== 64'h8000_0003) begin n_err++; $display("FAIL bstore_awaddr got=%h exp=80000003", o_awaddr); end
        n_vec++;
        if (o_err !== 1'b0 || o_lat !== 3) begin n_err++; $display("FAIL bstore_resp got err=%b lat=%0d exp err=0 lat=3", o_err, o_lat); end
        n_vec++;
        if (o_ar_hs !== 1'b0) begin n_err++; $display("FAIL bstore_no_ar got=%b exp=0", o_ar_hs); end
    endtask

    task automatic test_handshake_order;
        run_txn(0, 1, 64'h8000_0010, SIZE_D, 0, 64'h1122_3344_5566_7788, '0, 2'b00, 2'b00, 0, 0, 3, 0, 0, 0);
        n_vec++;
        if (o_aw_cyc !== 4) begin n_err++; $display("FAIL order_awvalid_cycles got=%0d exp=4", o_aw_cyc); end
        n_vec++;
        if (o_w_cyc !== 1) begin n_err++; $display("FAIL order_wvalid_cycles got=%0d exp=1", o_w_cyc); end
        n_vec++;
        if (o_bready_early !== 1'b0) begin n_err++; $display("FAIL order_bready_early got=1 exp=0"); end
        run_txn(0, 1, 64'h8000_0020, SIZE_W, 0, 64'hDEAD_BEEF, '0, 2'b00, 2'b00, 0, 0, 0, 2, 1, 0);
        n_vec++;
        if (o_aw_cyc !== 1 || o_w_cyc !== 3 || o_bready_early !== 1'b0) begin
            n_err++; $display("FAIL order_w_late got aw=%0d w=%0d early=%b exp 1/3/0", o_aw_cyc, o_w_cyc, o_bready_early);
        end
    endtask

    task automatic test_misaligned;
        run_txn(1, 0, 64'h8000_0002, SIZE_W, 0, '0, 64'h55, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if (o_bus_any !== 1'b0) begin n_err++; $display("FAIL mis_bus got=1 exp=0"); end
        n_vec++;
        if (o_lat !== 1 || o_err !== 1'b1 || o_rdata !== '0) begin
            n_err++; $display("FAIL mis_resp got lat=%0d err=%b rdata=%h exp 1/1/0", o_lat, o_err, o_rdata);
        end
        run_txn(0, 1, 64'h8000_0001, SIZE_H, 0, 64'hFFFF, '0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if (o_bus_any !== 1'b0 || o_err !== 1'b1) begin n_err++; $display("FAIL mis_store got bus=%b err=%b exp 0/1", o_bus_any, o_err); end
        run_txn(0, 0, 64'h8000_0000, SIZE_D, 0, '0, '0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if (o_bus_any !== 1'b0 || o_lat !== 1 || o_err !== 1'b0 || o_rdata !== '0) begin
            n_err++; $display("FAIL noop got bus=%b lat=%0d err=%b rdata=%h exp 0/1/0/0", o_bus_any, o_lat, o_err, o_rdata);
        end
    endtask

    task automatic test_backpressure;
        run_txn(1, 0, 64'h8000_0008, SIZE_D, 0, '0, 64'h0123_4567_89AB_CDEF, 2'b00, 2'b00, 1, 2, 0, 0, 0, 5);
        n_vec++;
        if (o_unstable !== 1'b0 || o_rr_bad !== 1'b0) begin
            n_err++; $display("FAIL bp_stable got unstable=%b req_ready_hi=%b exp 0/0", o_unstable, o_rr_bad);
        end
        n_vec++;
        if (o_rdata !== 64'h0123_4567_89AB_CDEF) begin n_err++; $display("FAIL bp_rdata got=%h exp=0123456789abcdef", o_rdata); end
        n_vec++;
        if (o_req_ready_after !== 1'b1) begin n_err++; $display("FAIL bp_req_ready_after got=0 exp=1"); end
        run_txn(1, 0, 64'h8000_0004, SIZE_W, 1, '0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if (o_err !== 1'b1 || o_rdata !== '0) begin n_err++; $display("FAIL rresp_err got err=%b rdata=%h exp 1/0", o_err, o_rdata); end
        run_txn(0, 1, 64'h8000_0004, SIZE_W, 0, 64'h1, '0, 2'b00, 2'b11, 0, 0, 0, 0, 2, 0);
        n_vec++;
        if (o_err !== 1'b1 || o_rdata !== '0) begin n_err++; $display("FAIL bresp_err got err=%b rdata=%h exp 1/0", o_err, o_rdata); end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        req_valid = 1; req_wen = 1; req_ren = 0; req_addr = 64'h8000_0010; req_size = SIZE_D;
        req_wdata = 64'hCAFE; awready = 0; wready = 0;
        @(negedge clk);
        req_valid = 0;
        n_vec++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1) begin n_err++; $display("FAIL arst_pre got aw=%b w=%b exp 1/1", awvalid, wvalid); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (awvalid !== 1'b0 || wvalid !== 1'b0) begin n_err++; $display("FAIL arst_async got aw=%b w=%b exp 0/0", awvalid, wvalid); end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1 || awvalid !== 1'b0) begin n_err++; $display("FAIL arst_after got req_ready=%b aw=%b exp 1/0", req_ready, awvalid); end
    endtask

    task automatic test_random;
        for (int it = 0; it < 60; it++) begin
            logic [63:0] a, wd, bd, exp_rd, m;
            logic [1:0]  sz, rr, br;
            logic        ren, wen, sgn, mis, exp_err;
            a   = {32'h8000_0000 | 32'($urandom_range(0, 255)), $urandom};
            sz  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) a = a & ~((64'd1 << sz) - 1);
            ren = 1'($urandom_range(0, 1)); wen = 1'($urandom_range(0, 1)); sgn = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) begin ren = 0; wen = 0; end
            wd  = {$urandom, $urandom}; bd = {$urandom, $urandom};
            rr  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            br  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            mis = (a % (64'd1 << sz)) != 0;
            run_txn(ren, wen, a, sz, sgn, wd, bd, rr, br, $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
            if (mis)      begin exp_err = 1; exp_rd = '0; end
            else if (wen) begin exp_err = (br != 0); exp_rd = '0; end
            else if (ren) begin exp_err = (rr != 0); exp_rd = (rr != 0) ? '0 : ref_load(bd, a, sz, sgn); end
            else          begin exp_err = 0; exp_rd = '0; end
            n_vec++;
            if (o_timeout || o_err !== exp_err || o_rdata !== exp_rd) begin
                n_err++; $display("FAIL rnd%0d_resp got to=%b err=%b rdata=%h exp err=%b rdata=%h", it, o_timeout, o_err, o_rdata, exp_err, exp_rd);
            end
            n_vec++;
            if (o_ar_hs !== (!mis && !wen && ren) || o_aw_hs !== (!mis && wen)) begin
                n_err++; $display("FAIL rnd%0d_bus got ar=%b aw=%b exp ar=%b aw=%b", it, o_ar_hs, o_aw_hs, !mis && !wen && ren, !mis && wen);
            end
            if (!mis && wen) begin
                m = lane_mask(ref_strb(a, sz));
                n_vec++;
                if (o_awaddr !== a || o_awsize !== {1'b0, sz} || o_wstrb !== ref_strb(a, sz) ||
                    (o_wdata & m) !== ref_wlanes(wd, a, sz)) begin
                    n_err++; $display("FAIL rnd%0d_store got addr=%h strb=%h wdata=%h exp addr=%h strb=%h lanes=%h",
                                      it, o_awaddr, o_wstrb, o_wdata, a, ref_strb(a, sz), ref_wlanes(wd, a, sz));
                end
            end else if (!mis && ren) begin
                n_vec++;
                if (o_araddr !== a || o_arsize !== {1'b0, sz}) begin
                    n_err++; $display("FAIL rnd%0d_ar got=%h/%0d exp=%h/%0d", it, o_araddr, o_arsize, a, sz);
                end
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        test_signed_load;
        test_byte_store;
        test_handshake_order;
        test_misaligned;
        test_backpressure;
        test_async_reset;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
